aib_axi_traffic_chk: RTL and testbench

Synthesizable AXI4 traffic generator and checker that replaces scripted single-beat bench stimulus on the master side of `aib_axi_top`. It issues a programmable number of INCR write bursts, reads each burst back, and compares data and responses. It reports pass/fail counts, so the same stimulus runs in simulation, emulation and silicon bring-up across the AIB link. One transaction is in flight at a time.

---
 rtl/aib_axi_traffic_chk_if.sv | 67 ++++++
 rtl/aib_axi_traffic_chk.sv | 233 +++++++++++++++++++++++
 tb/tb_aib_axi_traffic_chk.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aib_axi_traffic_chk_if.sv
// AXI4 bus bundle between the traffic checker (master) and the device under exercise (slave).
`timescale 1ns/1ps
interface aib_axi_traffic_chk_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        output bready,
        input  bvalid, bresp, bid,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        output rready,
        input  rvalid, rdata, rresp, rid, rlast
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        input  bready,
        output bvalid, bresp, bid,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        input  rready,
        output rvalid, rdata, rresp, rid, rlast
    );
endinterface

// File: rtl/aib_axi_traffic_chk.sv
// AXI4 write/readback traffic generator and checker: INCR bursts, one transaction in flight.
//   state  | meaning
//   IDLE   | waiting for i_start
//   AW     | write address offered
//   W      | write beats streaming
//   B      | waiting for write response
//   AR     | read address offered
//   R      | read beats checked against the write pattern
//   NEXT   | step to the next transaction
//   DONE   | one-cycle end-of-run pulse
`timescale 1ns/1ps
module aib_axi_traffic_chk #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000),
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr,
    aib_axi_traffic_chk_if.master   axi,
    input  logic                    i_start,
    input  logic [15:0]             i_num_txn,
    input  logic [7:0]              i_burst_len,
    input  logic [DATA_WIDTH-1:0]   i_seed,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [15:0]             o_txn_cnt,
    output logic [15:0]             o_err_cnt,
    output logic [ADDR_WIDTH-1:0]   o_first_err_addr,
    output logic                    o_timeout
);

    localparam int          AXSIZE    = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0]  AXSIZE_V  = 3'(AXSIZE);
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             num_txn_q, num_txn_d;
    logic [7:0]              len_q, len_d;
    logic [15:0]             txn_q, txn_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   base_q, base_d;
    logic [7:0]              beat_q, beat_d;
    logic [15:0]             wdog_q, wdog_d;
    logic [15:0]             txn_cnt_q, txn_cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;
    logic                    first_err_seen_q, first_err_seen_d;
    logic                    timeout_q, timeout_d;

    logic [ID_WIDTH-1:0]     cur_id;
    logic [DATA_WIDTH-1:0]   cur_data;
    logic [DATA_WIDTH-1:0]   burst_beats;
    logic [ADDR_WIDTH-1:0]   burst_bytes;
    logic                    last_beat;
    logic                    err_evt;
    logic                    beat_evt;

    // Beat k of transaction t is base + k, where base already carries seed + t*B.
    assign cur_id      = ID_WIDTH'(txn_q);
    assign cur_data    = base_q + DATA_WIDTH'(beat_q);
    assign burst_beats = DATA_WIDTH'(len_q) + DATA_WIDTH'(1);
    assign burst_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << AXSIZE;
    assign last_beat   = (beat_q == len_q);

    always_comb begin
        state_d          = state_q;
        num_txn_d        = num_txn_q;
        len_d            = len_q;
        txn_d            = txn_q;
        addr_d           = addr_q;
        base_d           = base_q;
        beat_d           = beat_q;
        wdog_d           = '0;
        txn_cnt_d        = txn_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        first_err_seen_d = first_err_seen_q;
        timeout_d        = timeout_q;
        err_evt          = 1'b0;
        beat_evt         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    num_txn_d        = i_num_txn;
                    len_d            = i_burst_len;
                    base_d           = i_seed;
                    txn_d            = '0;
                    addr_d           = BASE_ADDR;
                    beat_d           = '0;
                    txn_cnt_d        = '0;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    first_err_seen_d = 1'b0;
                    timeout_d        = 1'b0;
                    state_d          = (i_num_txn == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                if (axi.awready) begin
                    beat_d  = '0;
                    state_d = S_W;
                end
            end
            S_W: begin
                if (axi.wready) begin
                    beat_evt = 1'b1;
                    beat_d   = beat_q + 8'd1;
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                if (axi.bvalid) begin
                    err_evt = (axi.bresp != 2'b00) || (axi.bid != cur_id);
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (axi.arready) begin
                    beat_d  = '0;
                    state_d = S_R;
                end
            end
            S_R: begin
                if (axi.rvalid) begin
                    beat_evt = 1'b1;
                    beat_d   = beat_q + 8'd1;
                    err_evt  = (axi.rresp != 2'b00) || (axi.rid != cur_id) ||
                               (axi.rdata != cur_data) || (axi.rlast != last_beat);
                    if (last_beat) state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                txn_cnt_d = txn_cnt_q + 16'd1;
                txn_d     = txn_q + 16'd1;
                addr_d    = addr_q + burst_bytes;
                base_d    = base_q + burst_beats;
                state_d   = (({1'b0, txn_q} + 17'd1) < {1'b0, num_txn_q}) ? S_AW : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Progress in the same cycle always wins over watchdog expiry.
        if ((state_q inside {S_AW, S_W, S_B, S_AR, S_R}) && (state_d == state_q) && !beat_evt) begin
            if (wdog_q == WDOG_LAST) begin
                timeout_d = 1'b1;
                err_evt   = 1'b1;
                state_d   = S_DONE;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end

        if (err_evt) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (!first_err_seen_q) begin
                first_err_seen_d = 1'b1;
                first_err_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_q          <= S_IDLE;
            num_txn_q        <= '0;
            len_q            <= '0;
            txn_q            <= '0;
            addr_q           <= '0;
            base_q           <= '0;
            beat_q           <= '0;
            wdog_q           <= '0;
            txn_cnt_q        <= '0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            first_err_seen_q <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            num_txn_q        <= num_txn_d;
            len_q            <= len_d;
            txn_q            <= txn_d;
            addr_q           <= addr_d;
            base_q           <= base_d;
            beat_q           <= beat_d;
            wdog_q           <= wdog_d;
            txn_cnt_q        <= txn_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_seen_q <= first_err_seen_d;
            timeout_q        <= timeout_d;
        end
    end

    // Handshake outputs decode the state flop directly so reset drops them asynchronously.
    assign axi.awvalid = (state_q == S_AW);
    assign axi.awaddr  = addr_q;
    assign axi.awid    = cur_id;
    assign axi.awlen   = len_q;
    assign axi.awsize  = AXSIZE_V;
    assign axi.awburst = 2'b01;

    assign axi.wvalid  = (state_q == S_W);
    assign axi.wdata   = cur_data;
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state_q == S_W) && last_beat;

    assign axi.bready  = (state_q == S_B);

    assign axi.arvalid = (state_q == S_AR);
    assign axi.araddr  = addr_q;
    assign axi.arid    = cur_id;
    assign axi.arlen   = len_q;
    assign axi.arsize  = AXSIZE_V;
    assign axi.arburst = 2'b01;

    assign axi.rready  = (state_q == S_R);

    assign o_busy           = (state_q != S_IDLE);
    assign o_done           = (state_q == S_DONE);
    assign o_txn_cnt        = txn_cnt_q;
    assign o_err_cnt        = err_cnt_q;
    assign o_first_err_addr = first_err_addr_q;
    assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_aib_axi_traffic_chk.sv
// Directed bench: loopback memory slave with fault modes, table of runs plus reset/timeout sequences.
`timescale 1ns/1ps
module tb_aib_axi_traffic_chk;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          IW   = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk_wr = 1'b0;
    logic          rst_wr = 1'b1;
    logic          i_start = 1'b0;
    logic [15:0]   i_num_txn = '0;
    logic [7:0]    i_burst_len = '0;
    logic [DW-1:0] i_seed = '0;
    logic          o_busy, o_done, o_timeout;
    logic [15:0]   o_txn_cnt, o_err_cnt;
    logic [AW-1:0] o_first_err_addr;

    aib_axi_traffic_chk_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    aib_axi_traffic_chk #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BASE_ADDR(BASE), .TIMEOUT(TO)
    ) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .axi(axi),
        .i_start(i_start), .i_num_txn(i_num_txn), .i_burst_len(i_burst_len), .i_seed(i_seed),
        .o_busy(o_busy), .o_done(o_done), .o_txn_cnt(o_txn_cnt), .o_err_cnt(o_err_cnt),
        .o_first_err_addr(o_first_err_addr), .o_timeout(o_timeout)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        logic [15:0] num;
        logic [7:0]  len;
        logic [31:0] seed;
        bit          stall, flip, berr, bad_rlast;
        logic [15:0] exp_txn, exp_err;
        logic [31:0] exp_first;
        int          exp_cyc;
    } case_t;

    case_t cases[7];

    int n_cmp = 0, n_bad = 0;
    int cyc, done_cyc, done_cnt, aw_rise, aw_fall;
    bit any_valid;

    bit          stall_en, flip_en, berr_en, bad_rlast_en, no_awready;
    logic [7:0]  cur_len;
    logic [31:0] cur_seed;
    logic [31:0] mem [4096];
    int aw_txn, w_txn, w_beat, w_word, w_total, r_txn, r_beat, r_word;
    int model_bad, wlast_bad;
    bit b_pend, r_pend;
    logic [3:0] b_id, r_id;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit rnd_ok();
        return !stall_en || ($urandom_range(0, 3) != 0);
    endfunction

    function automatic logic [31:0] exp_addr(input int t);
        return BASE + 32'(t) * (32'(cur_len) + 32'd1) * 32'd4;
    endfunction

    function automatic logic [31:0] exp_data(input int t, input int k);
        return cur_seed + 32'(t) * (32'(cur_len) + 32'd1) + 32'(k);
    endfunction

    task automatic model_clear();
        b_pend = 0; r_pend = 0;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rid = 0; axi.rlast = 0;
    endtask

    // Slave decisions for the coming rising edge; handshakes are resolved here since both sides are stable.
    task automatic slave_step();
        logic flip_hit;
        if (rst_wr) begin
            model_clear();
            return;
        end
        axi.bvalid = b_pend && rnd_ok();
        axi.bresp  = berr_en ? 2'b10 : 2'b00;
        axi.bid    = b_id;
        if (axi.bvalid && axi.bready) b_pend = 0;

        if (r_pend) begin
            flip_hit    = flip_en && (r_txn == 1) && (r_beat == 2);
            axi.rvalid  = rnd_ok();
            axi.rdata   = mem[(r_word + r_beat) & 4095] ^ {31'b0, flip_hit};
            axi.rlast   = bad_rlast_en ? 1'b0 : (r_beat == int'(cur_len));
            axi.rid     = r_id;
            axi.rresp   = 2'b00;
            if (axi.rvalid && axi.rready) begin
                if (r_beat == int'(cur_len)) begin
                    r_pend = 0;
                    r_txn++;
                end
                r_beat++;
            end
        end else begin
            axi.rvalid = 0;
            axi.rlast  = 0;
        end

        axi.wready = rnd_ok();
        if (axi.wvalid && axi.wready) begin
            if (axi.wdata !== exp_data(w_txn, w_beat) || axi.wstrb !== 4'hF) model_bad++;
            if (axi.wlast !== (w_beat == int'(cur_len))) wlast_bad++;
            mem[(w_word + w_beat) & 4095] = axi.wdata;
            if (axi.wlast) b_pend = 1;
            w_beat++;
            w_total++;
        end

        axi.awready = !no_awready && rnd_ok();
        if (axi.awvalid && axi.awready) begin
            if (axi.awaddr !== exp_addr(aw_txn) || axi.awlen !== cur_len || axi.awid !== 4'(aw_txn) ||
                axi.awsize !== 3'd2 || axi.awburst !== 2'b01) model_bad++;
            w_word = int'((axi.awaddr - BASE) >> 2);
            w_beat = 0;
            w_txn  = aw_txn;
            b_id   = axi.awid;
            aw_txn++;
        end

        axi.arready = rnd_ok();
        if (axi.arvalid && axi.arready) begin
            if (axi.araddr !== exp_addr(r_txn) || axi.arlen !== cur_len || axi.arid !== 4'(r_txn) ||
                axi.arsize !== 3'd2 || axi.arburst !== 2'b01) model_bad++;
            r_word = int'((axi.araddr - BASE) >> 2);
            r_beat = 0;
            r_id   = axi.arid;
            r_pend = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk_wr);
        cyc++;
        slave_step();
        if (o_done) done_cnt++;
        if (axi.awvalid || axi.wvalid || axi.arvalid) any_valid = 1;
        if (axi.awvalid && aw_rise == 0) aw_rise = cyc;
        else if (!axi.awvalid && aw_rise != 0 && aw_fall == 0) aw_fall = cyc;
    endtask

    task automatic start_run(input logic [15:0] num, input logic [7:0] len, input logic [31:0] seed);
        cur_len = len; cur_seed = seed;
        aw_txn = 0; w_txn = 0; w_beat = 0; w_total = 0; r_txn = 0; r_beat = 0;
        model_bad = 0; wlast_bad = 0; b_pend = 0; r_pend = 0;
        done_cnt = 0; any_valid = 0; aw_rise = 0; aw_fall = 0; cyc = 0; done_cyc = 0;
        i_num_txn = num; i_burst_len = len; i_seed = seed;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        while (!o_done && cyc < 20000) tick();
        chk({nm, "_done_seen"}, o_done, 1'b1);
        done_cyc = cyc;
        chk({nm, "_busy_in_done"}, o_busy, 1'b1);
        tick();
        tick();
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_valids"}, {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready}, 0);
        chk({nm, "_burst"}, {axi.awburst, axi.arburst}, 4'b0101);
        chk({nm, "_size"}, {axi.awsize, axi.arsize}, 6'b010_010);
        chk({nm, "_status"}, {o_busy, o_done, o_timeout}, 0);
        chk({nm, "_cnts"}, {o_txn_cnt, o_err_cnt}, 0);
        chk({nm, "_first"}, o_first_err_addr, 0);
        chk({nm, "_addr_data"}, {axi.awaddr, axi.wdata}, 0);
    endtask

    initial begin
        cases[0] = '{16'd4, 8'd3,   32'hABCD_1234, 0, 0, 0, 0, 16'd4, 16'd0, 32'h0,    49};
        cases[1] = '{16'd4, 8'd3,   32'h1234_5678, 0, 1, 0, 0, 16'd4, 16'd1, 32'h1010, 49};
        cases[2] = '{16'd3, 8'd3,   32'h0000_0000, 0, 0, 1, 0, 16'd3, 16'd3, 32'h1000, 37};
        cases[3] = '{16'd3, 8'd7,   32'hFFFF_FFFC, 1, 0, 0, 0, 16'd3, 16'd0, 32'h0,    0};
        cases[4] = '{16'd5, 8'd0,   32'h5555_AAAA, 0, 0, 0, 0, 16'd5, 16'd0, 32'h0,    31};
        cases[5] = '{16'd2, 8'd1,   32'h0F0F_0F0F, 0, 0, 0, 1, 16'd2, 16'd2, 32'h1000, 17};
        cases[6] = '{16'd2, 8'd255, 32'hCAFE_0000, 1, 0, 0, 0, 16'd2, 16'd0, 32'h0,    0};

        stall_en = 0; flip_en = 0; berr_en = 0; bad_rlast_en = 0; no_awready = 0;
        cur_len = 0; cur_seed = 0;
        model_clear();

        rst_wr = 1'b1;
        repeat (3) tick();
        check_reset("rst");
        rst_wr = 1'b0;
        repeat (2) tick();

        // Zero-length run: done on the first edge, no bus activity.
        start_run(16'd0, 8'd3, 32'h1);
        wait_done("num0");
        chk("num0_done_cyc", done_cyc, 1);
        chk("num0_no_valid", any_valid, 1'b0);
        chk("num0_txn", o_txn_cnt, 0);
        chk("num0_done_once", done_cnt, 1);

        // Watchdog: awready never rises.
        no_awready = 1;
        start_run(16'd2, 8'd3, 32'h0);
        wait_done("tmo");
        chk("tmo_aw_rise", aw_rise, 1);
        chk("tmo_aw_fall", aw_fall, 1 + TO);
        chk("tmo_done_cyc", done_cyc, 1 + TO);
        chk("tmo_flag", o_timeout, 1'b1);
        chk("tmo_err", o_err_cnt, 1);
        chk("tmo_txn", o_txn_cnt, 0);
        repeat (3) tick();
        chk("tmo_sticky", {o_timeout, o_busy}, 2'b10);
        no_awready = 0;

        for (int i = 0; i < 7; i++) begin
            string nm;
            nm = $sformatf("case%0d", i);
            stall_en = cases[i].stall; flip_en = cases[i].flip;
            berr_en = cases[i].berr; bad_rlast_en = cases[i].bad_rlast;
            start_run(cases[i].num, cases[i].len, cases[i].seed);
            wait_done(nm);
            if (cases[i].exp_cyc != 0) chk({nm, "_done_cyc"}, done_cyc, cases[i].exp_cyc);
            chk({nm, "_txn"}, o_txn_cnt, cases[i].exp_txn);
            chk({nm, "_err"}, o_err_cnt, cases[i].exp_err);
            chk({nm, "_first_addr"}, o_first_err_addr, cases[i].exp_first);
            chk({nm, "_timeout"}, o_timeout, 1'b0);
            chk({nm, "_done_once"}, done_cnt, 1);
            chk({nm, "_bus_model"}, model_bad, 0);
            chk({nm, "_wlast"}, wlast_bad, 0);
        end
        flip_en = 0; berr_en = 0; bad_rlast_en = 0;

        // Reset in the middle of a long write burst, then a clean restart.
        stall_en = 1;
        start_run(16'd2, 8'd255, 32'h7777_0000);
        while (w_total < 20 && cyc < 5000) tick();
        chk("midw_reached", (w_total >= 20) && axi.wvalid, 1'b1);
        rst_wr = 1'b1;
        #1;
        check_reset("midw_async");
        repeat (3) tick();
        check_reset("midw_held");
        rst_wr = 1'b0;
        repeat (2) tick();
        start_run(16'd2, 8'd255, 32'h0000_FF00);
        wait_done("restart");
        chk("restart_txn", o_txn_cnt, 2);
        chk("restart_err", o_err_cnt, 0);
        chk("restart_bus_model", model_bad, 0);
        chk("restart_wlast", wlast_bad, 0);
        chk("restart_beats", w_total, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
